// File: rtl/demux8x3_32b_reg_if.sv
// Producer/consumer bundle for the registered 1-to-8 result distributor.
// The master side drives words and consumer readies; the slave side is the distributor.
interface demux8x3_32b_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_e;
  logic [WIDTH-1:0] out_f;
  logic [WIDTH-1:0] out_g;
  logic [WIDTH-1:0] out_h;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic [CNT_W-1:0] xfer_cnt;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h,
    input  out_valid, xfer_cnt
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h,
    output out_valid, xfer_cnt
  );
endinterface

// File: rtl/demux8x3_32b_reg.sv
// Registered 1-to-8 ALU result distributor: eight single-entry lane buffers,
// each with a valid/ready handshake, plus a wrapping accepted-transfer counter.
module demux8x3_32b_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  demux8x3_32b_reg_if.slave  bus
);
  logic [WIDTH-1:0] lane_data [8];
  logic [7:0]       valid_vec;
  logic             ready;
  logic             accept;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Only the addressed lane gates the producer; other full lanes never block.
  assign ready  = ~valid_vec[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign accept = bus.in_valid & ready;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [WIDTH-1:0] data_reg;
      logic             valid_reg;
      logic             wr;

      assign wr = accept && (bus.in_sel == 3'(gi));

      // A write on the same edge as a drain keeps the lane valid with the new word.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end else begin
          if (wr) begin
            data_reg <= bus.in_data;
          end
          valid_reg <= wr | (valid_reg & ~bus.out_ready[gi]);
        end
      end

      assign lane_data[gi] = data_reg;
      assign valid_vec[gi] = valid_reg;
    end
  endgenerate

  always_comb begin
    cnt_next = cnt_reg;
    if (accept) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Lane index equals in_sel: lane 7 is out_a, lane 0 is out_h.
  assign bus.in_ready  = ready;
  assign bus.out_a     = lane_data[7];
  assign bus.out_b     = lane_data[6];
  assign bus.out_c     = lane_data[5];
  assign bus.out_d     = lane_data[4];
  assign bus.out_e     = lane_data[3];
  assign bus.out_f     = lane_data[2];
  assign bus.out_g     = lane_data[1];
  assign bus.out_h     = lane_data[0];
  assign bus.out_valid = valid_vec;
  assign bus.xfer_cnt  = cnt_reg;
endmodule

// File: tb/tb_demux8x3_32b_reg.sv
// Directed bench for demux8x3_32b_reg: reset, routing, backpressure,
// drain-with-write, streaming, counter wrap and mid-operation reset.
module tb_demux8x3_32b_reg;
  logic clk;
  logic rst;
  int   check_cnt;
  int   error_cnt;

  demux8x3_32b_reg_if #(.WIDTH(32), .CNT_W(16)) bus ();

  demux8x3_32b_reg #(.WIDTH(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_val(input logic [2:0] sel);
    case (sel)
      3'd7:    lane_val = bus.out_a;
      3'd6:    lane_val = bus.out_b;
      3'd5:    lane_val = bus.out_c;
      3'd4:    lane_val = bus.out_d;
      3'd3:    lane_val = bus.out_e;
      3'd2:    lane_val = bus.out_f;
      3'd1:    lane_val = bus.out_g;
      default: lane_val = bus.out_h;
    endcase
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] sel, input logic [31:0] data);
    bus.in_sel   = sel;
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    $display("xfer sel=%0d data=%h ready=%0b", sel, data, bus.in_ready);
    step();
  endtask

  logic [2:0]  route_sel  [4];
  logic [31:0] route_data [4];

  initial begin
    check_cnt = 0;
    error_cnt = 0;
    route_sel[0] = 3'b000; route_data[0] = 32'h10000000;
    route_sel[1] = 3'b010; route_data[1] = 32'h12345678;
    route_sel[2] = 3'b100; route_data[2] = 32'h12345678;
    route_sel[3] = 3'b111; route_data[3] = 32'h00000001;

    // Reset held with a live producer: nothing may be written.
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 3'b011;
    bus.in_data   = 32'hDEADBEEF;
    bus.out_ready = 8'h00;
    step();
    step();
    check("rst_valid", {24'd0, bus.out_valid}, 32'h0);
    check("rst_cnt", {16'd0, bus.xfer_cnt}, 32'h0);
    check("rst_out_e", bus.out_e, 32'h0);
    check("rst_out_a", bus.out_a, 32'h0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("idle_valid", {24'd0, bus.out_valid}, 32'h0);

    // Routing, consumers not ready; each word visible one cycle after accept.
    for (int i = 0; i < 4; i++) begin
      send(route_sel[i], route_data[i]);
      check($sformatf("route_data%0d", i), lane_val(route_sel[i]), route_data[i]);
      check($sformatf("route_vld%0d", i), {31'd0, bus.out_valid[route_sel[i]]}, 32'h1);
    end
    bus.in_valid = 1'b0;
    check("route_valid", {24'd0, bus.out_valid}, 32'h00000095);
    check("route_cnt", {16'd0, bus.xfer_cnt}, 32'd4);

    // Backpressure on full lane h, while lane g stays open.
    bus.in_sel   = 3'b000;
    bus.in_data  = 32'hFFFFFFFF;
    bus.in_valid = 1'b1;
    #1;
    check("bp_ready_h", {31'd0, bus.in_ready}, 32'h0);
    step();
    check("bp_out_h", bus.out_h, 32'h10000000);
    check("bp_cnt", {16'd0, bus.xfer_cnt}, 32'd4);
    bus.in_sel = 3'b001;
    #1;
    check("bp_ready_g", {31'd0, bus.in_ready}, 32'h1);
    send(3'b001, 32'hFFFFFFFF);
    check("bp_out_g", bus.out_g, 32'hFFFFFFFF);
    check("bp_cnt2", {16'd0, bus.xfer_cnt}, 32'd5);

    // Drain and write on lane f in the same cycle.
    bus.out_ready = 8'b0000_0100;
    bus.in_sel    = 3'b010;
    #1;
    check("dw_ready", {31'd0, bus.in_ready}, 32'h1);
    send(3'b010, 32'h10000001);
    check("dw_out_f", bus.out_f, 32'h10000001);
    check("dw_vld_f", {31'd0, bus.out_valid[2]}, 32'h1);
    bus.in_valid = 1'b0;
    step();
    check("dw_drained", {31'd0, bus.out_valid[2]}, 32'h0);
    check("dw_valid", {24'd0, bus.out_valid}, 32'h00000093);
    bus.out_ready = 8'h00;

    // Streaming into lane a with the consumer always ready.
    bus.out_ready = 8'b1000_0000;
    for (int i = 0; i < 10; i++) begin
      bus.in_sel = 3'b111;
      #1;
      check($sformatf("st_ready%0d", i), {31'd0, bus.in_ready}, 32'h1);
      send(3'b111, 32'hA0000000 + i);
      check($sformatf("st_out_a%0d", i), bus.out_a, 32'hA0000000 + i);
    end
    bus.in_valid = 1'b0;
    check("st_cnt", {16'd0, bus.xfer_cnt}, 32'd16);

    // Ready on every lane drains them all; data registers keep their words.
    bus.out_ready = 8'hFF;
    step();
    check("dr_valid", {24'd0, bus.out_valid}, 32'h0);
    check("dr_keep_h", bus.out_h, 32'h10000000);
    step();
    check("dr_idle", {24'd0, bus.out_valid}, 32'h0);

    // Counter wrap: bring it to all-ones, then one more accept.
    bus.out_ready = 8'b1000_0000;
    bus.in_sel    = 3'b111;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 65535 - 16; i++) begin
      bus.in_data = i;
      step();
    end
    check("wrap_max", {16'd0, bus.xfer_cnt}, 32'h0000FFFF);
    send(3'b111, 32'h55AA55AA);
    check("wrap_zero", {16'd0, bus.xfer_cnt}, 32'h0);
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 8'h00;

    // Fill all lanes, then reset mid-operation.
    for (int s = 0; s < 8; s++) begin
      send(3'(s), 32'h0000_0100 + s);
    end
    bus.in_valid = 1'b0;
    check("fill_valid", {24'd0, bus.out_valid}, 32'h000000FF);
    check("fill_out_c", bus.out_c, 32'h00000105);
    check("fill_cnt", {16'd0, bus.xfer_cnt}, 32'd8);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 3'b101;
    bus.in_data  = 32'h77777777;
    step();
    check("mrst_valid", {24'd0, bus.out_valid}, 32'h0);
    check("mrst_cnt", {16'd0, bus.xfer_cnt}, 32'h0);
    for (int s = 0; s < 8; s++) begin
      check($sformatf("mrst_lane%0d", s), lane_val(3'(s)), 32'h0);
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end
endmodule
